// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// data load/store. Picks a winner, formats the word-aligned access (byte
// enables, store-lane replication) and returns aligned, extended load data.
// Only one transaction is outstanding at a time.
module mem_port_arbiter #(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic        instr_gnt,
    output logic        instr_rvalid,
    output logic [31:0] instr_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_byte,
    input  logic        data_zero_extnd,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,
    output logic        misaligned_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd3;

    localparam int SW = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    // Access is rejected when the size is reserved or the address is not
    // naturally aligned for the size.
    function automatic logic misaligned_f(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_en_f(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lo;
            SZ_HALF: be = 4'b0011 << lo;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the LSB-justified store data onto every lane so the byte
    // enables alone select the written bytes.
    function automatic logic [31:0] lanes_f(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] v;
        case (size)
            SZ_BYTE: v = {4{wd[7:0]}};
            SZ_HALF: v = {2{wd[15:0]}};
            default: v = wd;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] load_f(input logic [1:0] size, input logic zext,
                                           input logic [1:0] lo, input logic [31:0] rd);
        logic [31:0] sh;
        logic [31:0] v;
        sh = rd >> {lo, 3'b000};
        case (size)
            SZ_BYTE: v = {{24{~zext & sh[7]}}, sh[7:0]};
            SZ_HALF: v = {{16{~zext & sh[15]}}, sh[15:0]};
            default: v = rd;
        endcase
        return v;
    endfunction

    logic [1:0]    state_r;
    logic [SW-1:0] streak_r;
    logic          owner_data_r;
    logic [1:0]    size_r;
    logic          zext_r;
    logic          we_r;
    logic [1:0]    lo_r;
    logic          mem_req_r;
    logic          mem_we_r;
    logic [3:0]    mem_be_r;
    logic [31:0]   mem_addr_r;
    logic [31:0]   mem_wdata_r;
    logic          instr_rvalid_r;
    logic [31:0]   instr_rdata_r;
    logic          data_rvalid_r;
    logic [31:0]   data_rdata_r;
    logic          mis_err_r;

    logic          fetch_forced_s;
    logic          pick_data_s;
    logic          pick_instr_s;
    logic          data_bad_s;
    logic [SW-1:0] streak_next_s;
    logic          unused_addr_bits_s;

    assign data_bad_s         = misaligned_f(data_byte, data_addr[1:0]);
    assign unused_addr_bits_s = ^instr_addr[1:0];

    // Arbitration: data wins unless fetch has waited through a full data streak.
    always_comb begin
        fetch_forced_s = instr_req & (streak_r == STREAK_MAX);
        pick_data_s    = 1'b0;
        pick_instr_s   = 1'b0;
        if (state_r == ST_IDLE) begin
            if (data_req & ~fetch_forced_s) begin
                pick_data_s = 1'b1;
            end else if (instr_req) begin
                pick_instr_s = 1'b1;
            end else begin
                pick_data_s  = 1'b0;
                pick_instr_s = 1'b0;
            end
        end else begin
            pick_data_s  = 1'b0;
            pick_instr_s = 1'b0;
        end
    end

    // Streak counts data wins while fetch waits; anything else clears it.
    always_comb begin
        streak_next_s = streak_r;
        if (state_r == ST_IDLE) begin
            if (pick_data_s & instr_req) begin
                streak_next_s = (streak_r == STREAK_MAX) ? streak_r : streak_r + 1'b1;
            end else begin
                streak_next_s = {SW{1'b0}};
            end
        end else begin
            streak_next_s = streak_r;
        end
    end

    // Sequencer FSM: latch the winner, drive memory, register the response.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            streak_r       <= {SW{1'b0}};
            owner_data_r   <= 1'b0;
            size_r         <= 2'd0;
            zext_r         <= 1'b0;
            we_r           <= 1'b0;
            lo_r           <= 2'd0;
            mem_req_r      <= 1'b0;
            mem_we_r       <= 1'b0;
            mem_be_r       <= 4'd0;
            mem_addr_r     <= 32'd0;
            mem_wdata_r    <= 32'd0;
            instr_rvalid_r <= 1'b0;
            instr_rdata_r  <= 32'd0;
            data_rvalid_r  <= 1'b0;
            data_rdata_r   <= 32'd0;
            mis_err_r      <= 1'b0;
        end else begin
            instr_rvalid_r <= 1'b0;
            data_rvalid_r  <= 1'b0;
            mis_err_r      <= 1'b0;
            streak_r       <= streak_next_s;
            case (state_r)
                ST_IDLE: begin
                    if (pick_data_s) begin
                        owner_data_r <= 1'b1;
                        size_r       <= data_byte;
                        zext_r       <= data_zero_extnd;
                        we_r         <= data_wr;
                        lo_r         <= data_addr[1:0];
                        if (data_bad_s) begin
                            state_r <= ST_ERR;
                        end else begin
                            state_r     <= ST_REQ;
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= data_wr;
                            mem_be_r    <= byte_en_f(data_byte, data_addr[1:0]);
                            mem_addr_r  <= {data_addr[31:2], 2'b00};
                            mem_wdata_r <= lanes_f(data_byte, data_wdata);
                        end
                    end else if (pick_instr_s) begin
                        owner_data_r <= 1'b0;
                        size_r       <= SZ_WORD;
                        zext_r       <= 1'b0;
                        we_r         <= 1'b0;
                        lo_r         <= 2'd0;
                        state_r      <= ST_REQ;
                        mem_req_r    <= 1'b1;
                        mem_we_r     <= 1'b0;
                        mem_be_r     <= 4'b1111;
                        mem_addr_r   <= {instr_addr[31:2], 2'b00};
                        mem_wdata_r  <= 32'd0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        state_r   <= ST_RESP;
                        mem_req_r <= 1'b0;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_RESP: begin
                    if (mem_rvalid) begin
                        state_r <= ST_IDLE;
                        if (owner_data_r) begin
                            data_rvalid_r <= 1'b1;
                            data_rdata_r  <= we_r ? 32'd0 : load_f(size_r, zext_r, lo_r, mem_rdata);
                        end else begin
                            instr_rvalid_r <= 1'b1;
                            instr_rdata_r  <= mem_rdata;
                        end
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                ST_ERR: begin
                    state_r       <= ST_IDLE;
                    data_rvalid_r <= 1'b1;
                    mis_err_r     <= 1'b1;
                    data_rdata_r  <= 32'd0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Grants must coincide with the memory accept, so they decode the state
    // register together with mem_gnt; the error grant is the ERR state itself.
    assign instr_gnt      = (state_r == ST_REQ) & mem_gnt & ~owner_data_r;
    assign data_gnt       = ((state_r == ST_REQ) & mem_gnt & owner_data_r) | (state_r == ST_ERR);
    assign instr_rvalid   = instr_rvalid_r;
    assign instr_rdata    = instr_rdata_r;
    assign data_rvalid    = data_rvalid_r;
    assign data_rdata     = data_rdata_r;
    assign misaligned_err = mis_err_r;
    assign mem_req        = mem_req_r;
    assign mem_we         = mem_we_r;
    assign mem_be         = mem_be_r;
    assign mem_addr       = mem_addr_r;
    assign mem_wdata      = mem_wdata_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a memory responder with
// programmable stalls, and a scoreboard of expected memory accesses and
// requester responses filled as stimulus is driven.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_byte;
    logic        data_zero_extnd;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        misaligned_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    typedef struct packed {
        logic        is_data;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } mem_t;

    resp_t       exp_q[$];
    mem_t        mem_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          gnt_stall = 0;
    int          rv_wait = 0;
    int          stall_cnt = 0;
    int          resp_cnt = 0;
    int          rvalid_cnt = 0;
    logic [31:0] rdata_cfg = 32'd0;
    logic        mem_req_seen = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_DATA_STREAK(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
        .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_byte(data_byte),
        .data_zero_extnd(data_zero_extnd), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .misaligned_err(misaligned_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, "_ctrl"}, {21'd0, instr_gnt, instr_rvalid, data_gnt, data_rvalid,
                               misaligned_err, mem_req, mem_we, mem_be}, 32'd0);
        check({tag, "_instr_rdata"}, instr_rdata, 32'd0);
        check({tag, "_data_rdata"}, data_rdata, 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    // Response monitor: pops the scoreboard on every requester rvalid.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (mem_req) mem_req_seen = 1'b1;
            if (instr_gnt | data_gnt | instr_rvalid | data_rvalid)
                check("onehot", 32'($onehot0({instr_gnt, data_gnt, instr_rvalid, data_rvalid})), 32'd1);
            if (instr_rvalid | data_rvalid) begin
                rvalid_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rv_owner", 32'(data_rvalid), 32'(e.is_data));
                    if (e.is_data) begin
                        check("data_rdata", data_rdata, e.rdata);
                        check("misaligned_err", 32'(misaligned_err), 32'(e.err));
                    end else begin
                        check("instr_rdata", instr_rdata, e.rdata);
                    end
                end
            end
        end
    end

    // Memory responder: grants after gnt_stall cycles, answers rv_wait cycles later.
    initial begin
        mem_t m;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = rdata_cfg;
                end
            end else if (mem_req) begin
                if (stall_cnt < gnt_stall) begin
                    stall_cnt++;
                end else begin
                    stall_cnt = 0;
                    mem_gnt = 1'b1;
                    resp_cnt = rv_wait + 1;
                    if (mem_q.size() == 0) begin
                        check("unexpected_mem_access", 32'd1, 32'd0);
                    end else begin
                        m = mem_q.pop_front();
                        check("mem_addr", mem_addr, m.addr);
                        check("mem_be", 32'(mem_be), 32'(m.be));
                        check("mem_we", 32'(mem_we), 32'(m.we));
                        if (m.we) check("mem_wdata", mem_wdata, m.wdata);
                    end
                end
            end else begin
                stall_cnt = 0;
            end
        end
    end

    // One request from one requester; returns grant and rvalid cycle offsets
    // counted from the cycle in which the request is first sampled.
    task automatic issue(input logic is_d, input logic wr, input logic [1:0] sz, input logic zx,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] e_rdata, input logic e_err, input logic e_mem,
                         input logic [31:0] e_maddr, input logic [3:0] e_be, input logic [31:0] e_wdata,
                         output int gnt_lat, output int rv_lat);
        resp_t r;
        mem_t  m;
        @(posedge clk);
        #1;
        r.is_data = is_d; r.rdata = e_rdata; r.err = e_err;
        exp_q.push_back(r);
        if (e_mem) begin
            m.addr = e_maddr; m.be = e_be; m.we = wr & is_d; m.wdata = e_wdata;
            mem_q.push_back(m);
        end
        if (is_d) begin
            data_req = 1'b1; data_wr = wr; data_byte = sz; data_zero_extnd = zx;
            data_addr = addr; data_wdata = wd;
        end else begin
            instr_req = 1'b1; instr_addr = addr;
        end
        gnt_lat = -1;
        rv_lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((is_d && data_gnt) || (!is_d && instr_gnt)) begin
                gnt_lat = i;
                break;
            end
        end
        @(posedge clk);
        #1;
        data_req = 1'b0;
        instr_req = 1'b0;
        if (gnt_lat < 0) begin
            check("gnt_timeout", 32'd0, 32'd1);
        end else begin
            for (int i = gnt_lat + 1; i < gnt_lat + 60; i++) begin
                @(negedge clk);
                if (data_rvalid || instr_rvalid) begin
                    rv_lat = i;
                    break;
                end
            end
            if (rv_lat < 0) check("rvalid_timeout", 32'd0, 32'd1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int r;
        int ng;
        int rv_before;
        logic [8:0] pat;
        resp_t e;
        mem_t m;
        reset_n = 1'b0;
        instr_req = 1'b0; instr_addr = 32'd0;
        data_req = 1'b0; data_wr = 1'b0; data_byte = 2'd0; data_zero_extnd = 1'b0;
        data_addr = 32'd0; data_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outs_zero("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Fetch alone, zero-wait memory
        rdata_cfg = 32'hDEADBEEF;
        issue(1'b0, 1'b0, 2'd3, 1'b0, 32'h100, 32'd0, 32'hDEADBEEF, 1'b0, 1'b1,
              32'h100, 4'b1111, 32'd0, g, r);
        check("fetch_gnt_lat", 32'(g), 32'd1);
        check("fetch_rv_lat", 32'(r), 32'd3);
        rdata_cfg = 32'h01234567;
        issue(1'b0, 1'b0, 2'd3, 1'b0, 32'h103, 32'd0, 32'h01234567, 1'b0, 1'b1,
              32'h100, 4'b1111, 32'd0, g, r);

        // Loads with extension
        rdata_cfg = 32'h80112233;
        issue(1'b1, 1'b0, 2'd0, 1'b0, 32'h203, 32'd0, 32'hFFFFFF80, 1'b0, 1'b1,
              32'h200, 4'b1000, 32'd0, g, r);
        check("lb_rv_lat", 32'(r), 32'd3);
        issue(1'b1, 1'b0, 2'd0, 1'b1, 32'h203, 32'd0, 32'h00000080, 1'b0, 1'b1,
              32'h200, 4'b1000, 32'd0, g, r);
        issue(1'b1, 1'b0, 2'd0, 1'b0, 32'h201, 32'd0, 32'h00000022, 1'b0, 1'b1,
              32'h200, 4'b0010, 32'd0, g, r);
        issue(1'b1, 1'b0, 2'd1, 1'b0, 32'h202, 32'd0, 32'hFFFF8011, 1'b0, 1'b1,
              32'h200, 4'b1100, 32'd0, g, r);
        issue(1'b1, 1'b0, 2'd1, 1'b1, 32'h202, 32'd0, 32'h00008011, 1'b0, 1'b1,
              32'h200, 4'b1100, 32'd0, g, r);
        issue(1'b1, 1'b0, 2'd3, 1'b0, 32'h204, 32'd0, 32'h80112233, 1'b0, 1'b1,
              32'h204, 4'b1111, 32'd0, g, r);

        // Stores: lane replication, response data is zero
        rdata_cfg = 32'h5555AAAA;
        issue(1'b1, 1'b1, 2'd1, 1'b0, 32'h402, 32'h1234ABCD, 32'd0, 1'b0, 1'b1,
              32'h400, 4'b1100, 32'hABCDABCD, g, r);
        issue(1'b1, 1'b1, 2'd0, 1'b0, 32'h101, 32'h000000A5, 32'd0, 1'b0, 1'b1,
              32'h100, 4'b0010, 32'hA5A5A5A5, g, r);
        issue(1'b1, 1'b1, 2'd3, 1'b0, 32'h600, 32'hCAFEF00D, 32'd0, 1'b0, 1'b1,
              32'h600, 4'b1111, 32'hCAFEF00D, g, r);

        // Backpressure: 2 gnt stall cycles, 1 rvalid wait cycle
        gnt_stall = 2; rv_wait = 1; rdata_cfg = 32'h80112233;
        issue(1'b1, 1'b0, 2'd3, 1'b0, 32'h204, 32'd0, 32'h80112233, 1'b0, 1'b1,
              32'h204, 4'b1111, 32'd0, g, r);
        check("bp_gnt_lat", 32'(g), 32'd3);
        check("bp_rv_lat", 32'(r), 32'd6);
        gnt_stall = 0; rv_wait = 0;

        // Misaligned and reserved accesses never reach memory
        @(posedge clk);
        #1;
        mem_req_seen = 1'b0;
        issue(1'b1, 1'b0, 2'd3, 1'b0, 32'h102, 32'd0, 32'd0, 1'b1, 1'b0,
              32'd0, 4'd0, 32'd0, g, r);
        check("mis_gnt_lat", 32'(g), 32'd1);
        check("mis_rv_lat", 32'(r), 32'd2);
        issue(1'b1, 1'b0, 2'd1, 1'b0, 32'h101, 32'd0, 32'd0, 1'b1, 1'b0,
              32'd0, 4'd0, 32'd0, g, r);
        issue(1'b1, 1'b1, 2'd2, 1'b0, 32'h100, 32'h11111111, 32'd0, 1'b1, 1'b0,
              32'd0, 4'd0, 32'd0, g, r);
        check("mis_no_mem_req", 32'(mem_req_seen), 32'd0);

        // Starvation guard: both held, expect D D D D I D D D D
        rdata_cfg = 32'h11223344;
        pat = 9'b111101111;
        @(posedge clk);
        #1;
        for (int k = 0; k < 9; k++) begin
            e.is_data = pat[k]; e.rdata = 32'h11223344; e.err = 1'b0;
            exp_q.push_back(e);
            m.addr = pat[k] ? 32'h300 : 32'h500; m.be = 4'b1111; m.we = 1'b0; m.wdata = 32'd0;
            mem_q.push_back(m);
        end
        data_req = 1'b1; data_wr = 1'b0; data_byte = 2'd3; data_zero_extnd = 1'b0;
        data_addr = 32'h300; instr_req = 1'b1; instr_addr = 32'h500;
        ng = 0;
        for (int i = 0; i < 400 && ng < 9; i++) begin
            @(negedge clk);
            if (data_gnt || instr_gnt) begin
                check("starve_order", 32'(data_gnt), 32'(pat[ng]));
                ng++;
            end
        end
        @(posedge clk);
        #1;
        data_req = 1'b0;
        instr_req = 1'b0;
        check("starve_count", 32'(ng), 32'd9);
        repeat (10) @(negedge clk);
        check("starve_drain", 32'(exp_q.size()), 32'd0);

        // Stall three cycles, then reset during RESP
        gnt_stall = 3; rv_wait = 4; rdata_cfg = 32'h77777777;
        @(posedge clk);
        #1;
        m.addr = 32'h700; m.be = 4'b1111; m.we = 1'b0; m.wdata = 32'd0;
        mem_q.push_back(m);
        e.is_data = 1'b1; e.rdata = 32'h77777777; e.err = 1'b0;
        exp_q.push_back(e);
        data_req = 1'b1; data_wr = 1'b0; data_byte = 2'd3; data_addr = 32'h700;
        @(negedge clk);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("stall_mem_req", 32'(mem_req), 32'd1);
            check("stall_no_gnt", 32'(data_gnt), 32'd0);
        end
        @(negedge clk);
        check("stall_gnt", 32'(data_gnt), 32'd1);
        @(posedge clk);
        #1;
        data_req = 1'b0;
        reset_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_outs_zero("midreset");
        rv_before = rvalid_cnt;
        mem_req_seen = 1'b0;
        repeat (10) @(negedge clk);
        check("late_rvalid_ignored", 32'(rvalid_cnt - rv_before), 32'd0);
        check("post_reset_no_mem_req", 32'(mem_req_seen), 32'd0);
        gnt_stall = 0; rv_wait = 0;

        // Recovery after reset
        rdata_cfg = 32'h0BADF00D;
        issue(1'b0, 1'b0, 2'd3, 1'b0, 32'h800, 32'd0, 32'h0BADF00D, 1'b0, 1'b1,
              32'h800, 4'b1111, 32'd0, g, r);
        check("recover_rv_lat", 32'(r), 32'd3);

        repeat (4) @(negedge clk);
        check("final_resp_q_empty", 32'(exp_q.size()), 32'd0);
        check("final_mem_q_empty", 32'(mem_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
